// File: rtl/spi_pkg.sv
// Shared constants for the SPI slave: default frame width and the mode-0
// clock polarity/phase this block implements.
package spi_pkg;

  // Default number of bits per SPI frame.
  localparam int SPI_DATA_W = 8;

  // Mode 0: clock idles low, data sampled on the leading (rising) edge.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

endpackage : spi_pkg

// File: rtl/spi_slave.sv
// SPI mode-0 slave. Shifts mosi into a receive register and tx_data out on
// miso, one frame per DATA_W rising sclk edges. Slave select high acts as an
// asynchronous reset, so every frame starts from a clean state.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_W    = SPI_DATA_W,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              sclk,
  input  logic              ss,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_empty,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_data_available
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_next;

  // Receive register after absorbing the current mosi bit, in the chosen order.
  always_comb begin
    rx_next = '0;
    if (LSB_FIRST) begin
      rx_next = {mosi, rx_shift[DATA_W-1:1]};
    end else begin
      rx_next = {rx_shift[DATA_W-2:0], mosi};
    end
  end

  // Bit counter, shift registers and the completed-byte handshake.
  always_ff @(posedge sclk or posedge ss) begin
    if (ss) begin
      cnt               <= '0;
      rx_shift          <= '0;
      tx_shift          <= '0;
      rx_data           <= '0;
      rx_data_available <= 1'b0;
    end else begin
      rx_shift <= rx_next;

      if (cnt == CNT_LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // Bit 0 already went out combinationally from tx_data, so the register
      // is loaded pre-shifted and holds bit 1 at its output position.
      if (cnt == '0) begin
        tx_shift <= LSB_FIRST ? (tx_data >> 1) : (tx_data << 1);
      end else begin
        tx_shift <= LSB_FIRST ? (tx_shift >> 1) : (tx_shift << 1);
      end

      if (cnt == CNT_LAST) begin
        rx_data           <= rx_next;
        rx_data_available <= 1'b1;
      end else begin
        rx_data_available <= 1'b0;
      end
    end
  end

  // miso: bit 0 straight from tx_data at the frame start so it is valid as
  // soon as ss falls, then from the shift register; forced low when idle.
  always_comb begin
    miso = 1'b0;
    if (!ss) begin
      if (cnt == '0) begin
        miso = LSB_FIRST ? tx_data[0] : tx_data[DATA_W-1];
      end else begin
        miso = LSB_FIRST ? tx_shift[0] : tx_shift[DATA_W-1];
      end
    end
  end

  // Ready for a new transmit byte whenever the counter sits at a frame boundary.
  assign tx_empty = (cnt == '0);

endmodule : spi_slave

// File: tb/tb_spi_slave.sv
// Directed testbench for spi_slave: one LSB-first instance and one MSB-first
// instance share sclk/mosi/tx_data but have separate slave selects.
module tb_spi_slave;

  logic       sclk;
  logic       mosi;
  logic [7:0] tx_data;

  logic       ss_l;
  logic       miso_l;
  logic       tx_empty_l;
  logic [7:0] rx_data_l;
  logic       rx_avail_l;

  logic       ss_m;
  logic       miso_m;
  logic       tx_empty_m;
  logic [7:0] rx_data_m;
  logic       rx_avail_m;

  int vectors;
  int miscompares;

  spi_slave #(.DATA_W(8), .LSB_FIRST(1'b1)) dut_lsb (
    .sclk              (sclk),
    .ss                (ss_l),
    .mosi              (mosi),
    .miso              (miso_l),
    .tx_data           (tx_data),
    .tx_empty          (tx_empty_l),
    .rx_data           (rx_data_l),
    .rx_data_available (rx_avail_l)
  );

  spi_slave #(.DATA_W(8), .LSB_FIRST(1'b0)) dut_msb (
    .sclk              (sclk),
    .ss                (ss_m),
    .mosi              (mosi),
    .miso              (miso_m),
    .tx_data           (tx_data),
    .tx_empty          (tx_empty_m),
    .rx_data           (rx_data_m),
    .rx_data_available (rx_avail_m)
  );

  // One sclk period: rising edge, high phase, falling edge, low phase.
  task automatic pulse_sclk();
    #5 sclk = 1'b1;
    #5 sclk = 1'b0;
  endtask

  task automatic test_reset();
    ss_l = 1'b1; ss_m = 1'b1; mosi = 1'b0; tx_data = 8'h00;
    #3;
    vectors++;
    if (miso_l !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_miso got %b want 0", miso_l); end
    vectors++;
    if (tx_empty_l !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_tx_empty got %b want 1", tx_empty_l); end
    vectors++;
    if (rx_avail_l !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_avail got %b want 0", rx_avail_l); end
    vectors++;
    if (rx_data_l !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_rx_data got %h want 00", rx_data_l); end
    mosi = 1'b1; tx_data = 8'hFF;
    for (int i = 0; i < 3; i++) pulse_sclk();
    vectors++;
    if ({miso_l, tx_empty_l, rx_avail_l, rx_data_l} !== {3'b010, 8'h00}) begin
      miscompares++;
      $display("[TB] FAIL reset_sclk_ignored got miso=%b empty=%b avail=%b rx=%h want 0 1 0 00",
               miso_l, tx_empty_l, rx_avail_l, rx_data_l);
    end
  endtask

  task automatic test_basic_frame();
    logic [7:0] mosi_bits;
    logic [7:0] miso_exp;
    mosi_bits = 8'h50;
    miso_exp  = 8'h0D;
    tx_data = 8'h0D;
    ss_l = 1'b0;
    #2;
    for (int k = 0; k < 8; k++) begin
      mosi = mosi_bits[k];
      #1;
      vectors++;
      if (miso_l !== miso_exp[k]) begin
        miscompares++;
        $display("[TB] FAIL basic_miso_bit%0d got %b want %b", k, miso_l, miso_exp[k]);
      end
      pulse_sclk();
      if (k < 7) begin
        vectors++;
        if (tx_empty_l !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL basic_tx_empty_edge%0d got %b want 0", k + 1, tx_empty_l);
        end
      end
    end
    vectors++;
    if (rx_data_l !== 8'h50) begin miscompares++; $display("[TB] FAIL basic_rx_data got %h want 50", rx_data_l); end
    vectors++;
    if (rx_avail_l !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_avail got %b want 1", rx_avail_l); end
    vectors++;
    if (tx_empty_l !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_tx_empty_end got %b want 1", tx_empty_l); end
  endtask

  task automatic test_deselect();
    ss_l = 1'b1;
    #1;
    vectors++;
    if ({rx_avail_l, rx_data_l, miso_l} !== {1'b0, 8'h00, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL deselect_clear got avail=%b rx=%h miso=%b want 0 00 0",
               rx_avail_l, rx_data_l, miso_l);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] send [2];
    logic [7:0] txb  [2];
    logic [7:0] cur;
    send[0] = 8'hA5; send[1] = 8'h3C;
    txb[0]  = 8'hFF; txb[1]  = 8'h00;
    ss_l = 1'b0;
    #2;
    for (int f = 0; f < 2; f++) begin
      tx_data = txb[f];
      cur = send[f];
      for (int k = 0; k < 8; k++) begin
        mosi = cur[k];
        #1;
        vectors++;
        if (miso_l !== txb[f][k]) begin
          miscompares++;
          $display("[TB] FAIL b2b_miso_f%0d_bit%0d got %b want %b", f, k, miso_l, txb[f][k]);
        end
        pulse_sclk();
        if (f == 1 && k == 0) begin
          vectors++;
          if (rx_avail_l !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL b2b_avail_clear_edge9 got %b want 0", rx_avail_l);
          end
        end
      end
      vectors++;
      if (rx_data_l !== send[f] || rx_avail_l !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL b2b_rx_frame%0d got rx=%h avail=%b want %h 1", f, rx_data_l, rx_avail_l, send[f]);
      end
    end
    ss_l = 1'b1;
    #2;
  endtask

  task automatic test_abort();
    logic [7:0] cur;
    int pulses;
    tx_data = 8'h00;
    ss_l = 1'b0;
    #2;
    mosi = 1'b1;
    for (int k = 0; k < 4; k++) pulse_sclk();
    ss_l = 1'b1;
    #1;
    vectors++;
    if (rx_avail_l !== 1'b0 || tx_empty_l !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL abort_cleared got avail=%b empty=%b want 0 1", rx_avail_l, tx_empty_l);
    end
    ss_l = 1'b0;
    #2;
    cur = 8'h81;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      mosi = cur[k];
      pulse_sclk();
      if (rx_avail_l === 1'b1) pulses++;
    end
    vectors++;
    if (rx_data_l !== 8'h81) begin miscompares++; $display("[TB] FAIL abort_rx_data got %h want 81", rx_data_l); end
    vectors++;
    if (pulses != 1) begin miscompares++; $display("[TB] FAIL abort_pulse_count got %0d want 1", pulses); end
    ss_l = 1'b1;
    #2;
  endtask

  task automatic test_msb_first();
    logic [7:0] cur;
    logic [7:0] miso_exp;
    cur      = 8'h0A;
    miso_exp = 8'h0D;
    tx_data  = 8'h0D;
    ss_m = 1'b0;
    #2;
    for (int k = 7; k >= 0; k--) begin
      mosi = cur[k];
      #1;
      vectors++;
      if (miso_m !== miso_exp[k]) begin
        miscompares++;
        $display("[TB] FAIL msb_miso_bit%0d got %b want %b", k, miso_m, miso_exp[k]);
      end
      pulse_sclk();
    end
    vectors++;
    if (rx_data_m !== 8'h0A || rx_avail_m !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL msb_rx got rx=%h avail=%b want 0a 1", rx_data_m, rx_avail_m);
    end
    ss_m = 1'b1;
    #2;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    sclk = 1'b0;
    ss_l = 1'b1;
    ss_m = 1'b1;
    mosi = 1'b0;
    tx_data = 8'h00;
    test_reset();
    test_basic_frame();
    test_deselect();
    test_back_to_back();
    test_abort();
    test_msb_first();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_spi_slave

// File: doc/spi_slave.md
# spi_slave

SPI mode-0 slave (CPOL=0, CPHA=0) that exchanges one byte per 8 `sclk` rising edges while selected. It deserialises `mosi` into `rx_data` and serialises `tx_data` onto `miso`. Bytes are sent and received LSB first by default. It sits between an external SPI master and local logic, which supplies transmit bytes and consumes received bytes.

## Interface
- `DATA_W`, default 8: bits per frame.
- `LSB_FIRST`, default 1: 1 = bit 0 first on both lines; 0 = MSB first.

Ports:
- `sclk`  input  1  SPI clock and the block's only clock; all flops update on its rising edge.
- `ss`  input  1  slave select, active-low. It doubles as the block reset: `ss`=1 is an asynchronous, active-high reset.
- `mosi`  input  1  master-out data, sampled on `sclk` rising edges.
- `miso`  output  1  slave-out data.
- `tx_data`  input  DATA_W  byte to transmit; captured at frame bit 0.
- `tx_empty`  output  1  1 = ready for a new `tx_data` (bit counter is 0).
- `rx_data`  output  DATA_W  last completed received byte.
- `rx_data_available`  output  1  1 = `rx_data` holds a freshly completed byte.

## Operation
- State: bit counter `cnt` (0..DATA_W-1), receive shift register, transmit shift register, `rx_data` register, `rx_data_available` flag.
- While `ss`=1 (asynchronous reset):
  - `cnt`=0 and both shift registers are 0.
  - `rx_data`=0, `rx_data_available`=0, `tx_empty`=1, `miso`=0.
- While `ss`=0, on each `sclk` rising edge:
  - The incoming `mosi` bit is shifted in: into the MSB, shifting right, when LSB_FIRST; into the LSB, shifting left, otherwise.
  - `cnt` increments and wraps DATA_W-1 → 0.
- At `cnt`=0, the rising edge also loads the transmit shift register from `tx_data`, already shifted by one bit. The remaining bits are then clocked out on later edges.
- `miso` while selected:
  - At `cnt`=0, `miso` is combinational from `tx_data`: `tx_data[0]` (LSB_FIRST) or `tx_data[DATA_W-1]`.
  - At `cnt`=k>0, `miso` is the transmit bit of index k.
- `tx_empty` = (`cnt`==0) while selected, and 1 while deselected.
- Frame completion, on the rising edge where `cnt`==DATA_W-1:
  - `rx_data` is loaded with the full byte, including the bit sampled on that edge.
  - `rx_data_available` is set to 1.
- `rx_data_available` clears on the next `sclk` rising edge (the first bit of the next frame) or on `ss`=1.
- `rx_data` holds its value until the next frame completes or `ss` rises.
- Back-to-back frames run with no gap: after the wrap, `cnt`=0, `tx_empty`=1, and the next `tx_data` is taken on the next rising edge.
- Deselect mid-frame aborts the frame: the partial byte is discarded and no `rx_data_available` pulse occurs.

## Timing
- `mosi` is sampled on the rising edge; master sets it up while `sclk` is low.
- `miso` changes just after each rising edge and is stable for the master's next rising-edge sample.
- Bit 0 of `miso` is valid from `ss` falling, with `tx_data` stable before the first rising edge.
- `tx_data` must be valid at or before the first rising edge of a frame; it may change freely while `tx_empty`=0.
- Latency: `rx_data` and `rx_data_available` update on the DATA_W-th rising edge after `ss` falls. No internal pipeline.
- Local logic must capture `rx_data` while `rx_data_available`=1, before the next `sclk` rising edge or `ss` rising.

## Structure
- Shared package `spi_pkg`: constant for the default data width (8) and the mode-0 CPOL/CPHA constants.
- Single flat module, no sub-module; counter and both shift registers are inline.

## Test plan
- Power-up with `ss`=1:
  - `miso`=0, `tx_empty`=1, `rx_data_available`=0, `rx_data`=0x00.
  - Pulsing `sclk` while `ss`=1 changes nothing.
- `ss`=0, `tx_data`=0x0D, `mosi` LSB-first 0,0,0,0,1,0,1,0 over 8 edges:
  - `miso` sequence is 1,0,1,1,0,0,0,0.
  - After the 8th edge, `rx_data`=0x50, `rx_data_available`=1, `tx_empty`=1.
  - `tx_empty`=0 after edges 1-7.
- Then `ss`=1: `rx_data_available`=0, `rx_data`=0x00, `miso`=0 immediately, with no `sclk` edge needed.
- Two back-to-back frames sending 0xA5 then 0x3C, with `tx_data` 0xFF then 0x00:
  - `rx_data`=0xA5 after edge 8, and `rx_data_available` clears on edge 9.
  - `rx_data`=0x3C after edge 16.
  - `miso` is all 1s, then all 0s.
- Abort: `ss` raised after 4 edges, then a new full frame sending 0x81 → `rx_data`=0x81 with no stale bits and exactly one `rx_data_available` pulse.
- With LSB_FIRST=0, send 0x0A MSB-first with `tx_data`=0x0D → `rx_data`=0x0A, `miso` sequence 0,0,0,0,1,1,0,1.
